// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: free-running pixel/line counters with registered
// sync, data-enable, active-pixel coordinates and line/frame start strobes.
module vga_timing_gen #(
  parameter int HPULSE  = 96,
  parameter int HBP     = 48,
  parameter int HACTIVE = 640,
  parameter int HFP     = 16,
  parameter int VPULSE  = 2,
  parameter int VBP     = 33,
  parameter int VACTIVE = 480,
  parameter int VFP     = 10,
  parameter bit HS_POL  = 1'b0,
  parameter bit VS_POL  = 1'b0,
  localparam int XW = (HACTIVE > 1) ? $clog2(HACTIVE) : 1,
  localparam int YW = (VACTIVE > 1) ? $clog2(VACTIVE) : 1
) (
  input  logic          pixel_clk,
  input  logic          rst,
  input  logic          ce,
  output logic          vga_hs,
  output logic          vga_vs,
  output logic          data_en,
  output logic [XW-1:0] pix_x,
  output logic [YW-1:0] pix_y,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = HPULSE + HBP + HACTIVE + HFP;
  localparam int V_TOTAL = VPULSE + VBP + VACTIVE + VFP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int H_ACT_S = HPULSE + HBP;
  localparam int V_ACT_S = VPULSE + VBP;
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  function automatic logic in_range(input int c, input int lo, input int hi);
    return (c >= lo) && (c < hi);
  endfunction

  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic          hs_q, hs_d, vs_q, vs_d, de_q, de_d;
  logic          ls_q, ls_d, fs_q, fs_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          h_act, v_act;

  // Next counter values and decode of the current (pre-edge) counter values.
  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (hcnt_q == H_LAST) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
    end else begin
      hcnt_d = hcnt_q + 1'b1;
    end

    h_act = in_range(int'(hcnt_q), H_ACT_S, H_ACT_S + HACTIVE);
    v_act = in_range(int'(vcnt_q), V_ACT_S, V_ACT_S + VACTIVE);
    hs_d  = in_range(int'(hcnt_q), 0, HPULSE) ? HS_POL : ~HS_POL;
    vs_d  = in_range(int'(vcnt_q), 0, VPULSE) ? VS_POL : ~VS_POL;
    de_d  = h_act & v_act;
    x_d   = de_d ? XW'(int'(hcnt_q) - H_ACT_S) : '0;
    y_d   = de_d ? YW'(int'(vcnt_q) - V_ACT_S) : '0;
    ls_d  = (hcnt_q == '0);
    fs_d  = (hcnt_q == '0) && (vcnt_q == '0);
  end

  // Strobes are forced low on idle enables; everything else simply holds.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
      hs_q   <= ~HS_POL;
      vs_q   <= ~VS_POL;
      de_q   <= 1'b0;
      x_q    <= '0;
      y_q    <= '0;
      ls_q   <= 1'b0;
      fs_q   <= 1'b0;
    end else if (ce) begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      de_q   <= de_d;
      x_q    <= x_d;
      y_q    <= y_d;
      ls_q   <= ls_d;
      fs_q   <= fs_d;
    end else begin
      ls_q   <= 1'b0;
      fs_q   <= 1'b0;
    end
  end

  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign data_en     = de_q;
  assign pix_x       = x_q;
  assign pix_y       = y_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default timing, a tiny active-low raster and a tiny
// active-high raster, all checked cycle by cycle against a behavioural model.
module tb_vga_timing_gen;

  logic pixel_clk = 1'b0;
  logic rst;
  logic ce;

  always #5 pixel_clk = ~pixel_clk;

  logic       hs0, vs0, de0, ls0, fs0;
  logic [9:0] x0;
  logic [8:0] y0;
  logic       hs1, vs1, de1, ls1, fs1;
  logic [1:0] x1, y1;
  logic       hs2, vs2, de2, ls2, fs2;
  logic [1:0] x2, y2;

  vga_timing_gen dut_def (
    .pixel_clk(pixel_clk), .rst(rst), .ce(ce),
    .vga_hs(hs0), .vga_vs(vs0), .data_en(de0), .pix_x(x0), .pix_y(y0),
    .line_start(ls0), .frame_start(fs0)
  );

  vga_timing_gen #(
    .HPULSE(1), .HBP(1), .HACTIVE(4), .HFP(1),
    .VPULSE(1), .VBP(1), .VACTIVE(3), .VFP(1),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut_sm (
    .pixel_clk(pixel_clk), .rst(rst), .ce(ce),
    .vga_hs(hs1), .vga_vs(vs1), .data_en(de1), .pix_x(x1), .pix_y(y1),
    .line_start(ls1), .frame_start(fs1)
  );

  vga_timing_gen #(
    .HPULSE(1), .HBP(1), .HACTIVE(4), .HFP(1),
    .VPULSE(1), .VBP(1), .VACTIVE(3), .VFP(1),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut_pol (
    .pixel_clk(pixel_clk), .rst(rst), .ce(ce),
    .vga_hs(hs2), .vga_vs(vs2), .data_en(de2), .pix_x(x2), .pix_y(y2),
    .line_start(ls2), .frame_start(fs2)
  );

  typedef struct {
    int   p;
    logic hs, vs, de, ls, fs;
    int   x, y;
  } exp_t;

  int   HP[3]  = '{96, 1, 1};
  int   HB[3]  = '{48, 1, 1};
  int   HA[3]  = '{640, 4, 4};
  int   HF[3]  = '{16, 1, 1};
  int   VP[3]  = '{2, 1, 1};
  int   VB[3]  = '{33, 1, 1};
  int   VA[3]  = '{480, 3, 3};
  int   VF[3]  = '{10, 1, 1};
  logic HPOL[3] = '{1'b0, 1'b0, 1'b1};
  logic VPOL[3] = '{1'b0, 1'b0, 1'b1};

  int   mh[3], mv[3];
  exp_t mlast[3];
  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t reset_exp(int p);
    exp_t e;
    e.p = p; e.hs = ~HPOL[p]; e.vs = ~VPOL[p];
    e.de = 1'b0; e.ls = 1'b0; e.fs = 1'b0; e.x = 0; e.y = 0;
    return e;
  endfunction

  function automatic exp_t decode(int p, int h, int v);
    exp_t e;
    logic ha, va;
    e.p  = p;
    e.hs = (h < HP[p]) ? HPOL[p] : ~HPOL[p];
    e.vs = (v < VP[p]) ? VPOL[p] : ~VPOL[p];
    ha   = (h >= HP[p] + HB[p]) && (h < HP[p] + HB[p] + HA[p]);
    va   = (v >= VP[p] + VB[p]) && (v < VP[p] + VB[p] + VA[p]);
    e.de = ha && va;
    e.x  = e.de ? h - (HP[p] + HB[p]) : 0;
    e.y  = e.de ? v - (VP[p] + VB[p]) : 0;
    e.ls = (h == 0);
    e.fs = (h == 0) && (v == 0);
    return e;
  endfunction

  function automatic exp_t get_obs(int p);
    exp_t o;
    o.p = p;
    case (p)
      0: begin o.hs = hs0; o.vs = vs0; o.de = de0; o.ls = ls0; o.fs = fs0; o.x = int'(x0); o.y = int'(y0); end
      1: begin o.hs = hs1; o.vs = vs1; o.de = de1; o.ls = ls1; o.fs = fs1; o.x = int'(x1); o.y = int'(y1); end
      default: begin o.hs = hs2; o.vs = vs2; o.de = de2; o.ls = ls2; o.fs = fs2; o.x = int'(x2); o.y = int'(y2); end
    endcase
    return o;
  endfunction

  task automatic compare(input exp_t o, input exp_t e, input string what);
    chk($sformatf("d%0d.%s.hs@%0d", e.p, what, cyc), o.hs, e.hs);
    chk($sformatf("d%0d.%s.vs@%0d", e.p, what, cyc), o.vs, e.vs);
    chk($sformatf("d%0d.%s.de@%0d", e.p, what, cyc), o.de, e.de);
    chk($sformatf("d%0d.%s.x@%0d",  e.p, what, cyc), o.x,  e.x);
    chk($sformatf("d%0d.%s.y@%0d",  e.p, what, cyc), o.y,  e.y);
    chk($sformatf("d%0d.%s.ls@%0d", e.p, what, cyc), o.ls, e.ls);
    chk($sformatf("d%0d.%s.fs@%0d", e.p, what, cyc), o.fs, e.fs);
  endtask

  task automatic model_reset();
    for (int p = 0; p < 3; p++) begin
      mh[p] = 0; mv[p] = 0; mlast[p] = reset_exp(p);
    end
  endtask

  // One pixel clock: drive on the falling edge, push expectations, check after rise.
  task automatic step(input logic c, input logic r);
    exp_t e, o;
    @(negedge pixel_clk);
    ce = c; rst = r;
    for (int p = 0; p < 3; p++) begin
      if (r) begin
        mh[p] = 0; mv[p] = 0; e = reset_exp(p);
      end else if (c) begin
        e = decode(p, mh[p], mv[p]);
        if (mh[p] == HP[p] + HB[p] + HA[p] + HF[p] - 1) begin
          mh[p] = 0;
          mv[p] = (mv[p] == VP[p] + VB[p] + VA[p] + VF[p] - 1) ? 0 : mv[p] + 1;
        end else begin
          mh[p] = mh[p] + 1;
        end
      end else begin
        e = mlast[p]; e.ls = 1'b0; e.fs = 1'b0;
      end
      mlast[p] = e;
      sbq.push_back(e);
    end
    @(posedge pixel_clk);
    #1;
    cyc++;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      o = get_obs(e.p);
      compare(o, e, "sb");
    end
  endtask

  initial begin
    exp_t o0, o1;
    int ls_prev = -1, hslow = 0, fs0_at = -1, fs1_prev = -1, decnt = 0;
    bit de0_seen = 1'b0;

    rst = 1'b1;
    ce  = 1'b0;
    model_reset();
    #1;
    for (int p = 0; p < 3; p++) compare(get_obs(p), reset_exp(p), "rst0");
    repeat (3) step(1'b1, 1'b1);

    // Free-running with ce high: enough to reach the first default active pixel.
    for (int i = 0; i < 29000; i++) begin
      step(1'b1, 1'b0);
      o0 = get_obs(0);
      o1 = get_obs(1);
      if (o0.ls) begin
        if (ls_prev >= 0) begin
          chk("def.ls_period", cyc - ls_prev, 800);
          chk("def.hs_low_per_line", hslow, 96);
        end
        ls_prev = cyc;
        hslow = 0;
      end
      if (!o0.hs) hslow++;
      if (o0.fs) fs0_at = cyc;
      if (o0.de && !de0_seen) begin
        de0_seen = 1'b1;
        chk("def.first_de_delay", cyc - fs0_at, 28144);
        chk("def.first_x", o0.x, 0);
        chk("def.first_y", o0.y, 0);
      end
      if (o1.fs) begin
        if (fs1_prev >= 0) begin
          chk("sm.fs_period", cyc - fs1_prev, 42);
          chk("sm.de_per_frame", decnt, 12);
        end
        fs1_prev = cyc;
        decnt = 0;
      end
      if (o1.de) decnt++;
    end
    chk("def.first_de_seen", de0_seen, 1'b1);

    // Alternating and random clock enable.
    for (int i = 0; i < 400; i++) step(logic'(i[0] == 1'b0), 1'b0);
    for (int i = 0; i < 300; i++) step(logic'($urandom_range(0, 1)), 1'b0);

    // Asynchronous reset mid-frame: outputs must clear before any clock edge.
    @(negedge pixel_clk);
    rst = 1'b1;
    #1;
    for (int p = 0; p < 3; p++) compare(get_obs(p), reset_exp(p), "async_rst");
    model_reset();
    repeat (2) step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    chk("def.fs_after_rst", fs0, 1'b1);
    chk("pol.vs_after_rst", vs2, 1'b1);
    for (int i = 0; i < 300; i++) step(1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
